// File: rtl/ifetch_seq.sv
// Byte-serial instruction fetch sequencer: requests one byte per memory ack,
// assembles icode/ifun, register specifiers and a little-endian constant, then presents them.
module ifetch_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] pc_in,
    input  logic        pc_valid,
    output logic        mem_req,
    output logic [63:0] mem_addr,
    input  logic        mem_ack,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_err,
    output logic [3:0]  icode,
    output logic [3:0]  ifun,
    output logic [3:0]  rA,
    output logic [3:0]  rB,
    output logic [63:0] valC,
    output logic [63:0] valP,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic        instr_err,
    output logic        imem_error
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        DONE   = 2'd2,
        HALTED = 2'd3
    } state_t;

    // Total instruction length in bytes, keyed by icode.
    function automatic logic [3:0] instr_len(input logic [3:0] code);
        logic [3:0] len;
        case (code)
            4'h0, 4'h1, 4'h9:        len = 4'd1;
            4'h2, 4'h6, 4'hA, 4'hB:  len = 4'd2;
            4'h7, 4'h8:              len = 4'd9;
            4'h3, 4'h4, 4'h5:        len = 4'd10;
            default:                 len = 4'd1;
        endcase
        return len;
    endfunction

    // Instructions whose byte 1 carries rA/rB.
    function automatic logic has_reg(input logic [3:0] code);
        logic r;
        case (code)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: r = 1'b1;
            default:                                  r = 1'b0;
        endcase
        return r;
    endfunction

    state_t      state_q, state_d;
    logic [63:0] base_q, base_d;
    logic [63:0] addr_q, addr_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  len_q, len_d;
    logic [3:0]  icode_q, icode_d;
    logic [3:0]  ifun_q, ifun_d;
    logic [3:0]  ra_q, ra_d;
    logic [3:0]  rb_q, rb_d;
    logic [63:0] valc_q, valc_d;
    logic [63:0] valp_q, valp_d;
    logic        ierr_q, ierr_d;
    logic        merr_q, merr_d;
    logic        req_q, req_d;
    logic        valid_q, valid_d;

    logic [3:0]  cur_len_s;
    logic [3:0]  byte_idx_s;

    // Next-state and field-capture logic.
    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        icode_d    = icode_q;
        ifun_d     = ifun_q;
        ra_d       = ra_q;
        rb_d       = rb_q;
        valc_d     = valc_q;
        valp_d     = valp_q;
        ierr_d     = ierr_q;
        merr_d     = merr_q;
        cur_len_s  = (cnt_q == 4'd0) ? instr_len(mem_rdata[7:4]) : len_q;
        byte_idx_s = cnt_q - (has_reg(icode_q) ? 4'd2 : 4'd1);

        case (state_q)
            IDLE: begin
                if (pc_valid) begin
                    state_d = REQ;
                    base_d  = pc_in;
                    addr_d  = pc_in;
                    cnt_d   = 4'd0;
                    len_d   = 4'd1;
                    icode_d = 4'h0;
                    ifun_d  = 4'h0;
                    ra_d    = 4'hF;
                    rb_d    = 4'hF;
                    valc_d  = 64'd0;
                    valp_d  = 64'd0;
                    ierr_d  = 1'b0;
                    merr_d  = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (mem_ack && mem_err) begin
                    // Abort: keep whatever fields were already captured.
                    state_d = DONE;
                    merr_d  = 1'b1;
                    valp_d  = base_q;
                end else if (mem_ack) begin
                    addr_d = addr_q + 64'd1;
                    cnt_d  = cnt_q + 4'd1;
                    if (cnt_q == 4'd0) begin
                        icode_d = mem_rdata[7:4];
                        ifun_d  = mem_rdata[3:0];
                        len_d   = cur_len_s;
                        ierr_d  = (mem_rdata[7:4] > 4'hB);
                    end else if (has_reg(icode_q) && (cnt_q == 4'd1)) begin
                        ra_d = mem_rdata[7:4];
                        rb_d = mem_rdata[3:0];
                    end else begin
                        valc_d[{byte_idx_s[2:0], 3'b000} +: 8] = mem_rdata;
                    end
                    if ((cnt_q + 4'd1) == cur_len_s) begin
                        state_d = DONE;
                        valp_d  = base_q + {60'd0, cur_len_s};
                    end else begin
                        state_d = REQ;
                    end
                end else begin
                    state_d = REQ;
                end
            end
            DONE: begin
                if (instr_ready) begin
                    state_d = ((icode_q == 4'h0) || ierr_q || merr_q) ? HALTED : IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            HALTED: begin
                state_d = HALTED;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        req_d   = (state_d == REQ);
        valid_d = (state_d == DONE);
    end

    // State and output registers; synchronous reset wins over every other input.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            base_q  <= 64'd0;
            addr_q  <= 64'd0;
            cnt_q   <= 4'd0;
            len_q   <= 4'd1;
            icode_q <= 4'h0;
            ifun_q  <= 4'h0;
            ra_q    <= 4'hF;
            rb_q    <= 4'hF;
            valc_q  <= 64'd0;
            valp_q  <= 64'd0;
            ierr_q  <= 1'b0;
            merr_q  <= 1'b0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            icode_q <= icode_d;
            ifun_q  <= ifun_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            valc_q  <= valc_d;
            valp_q  <= valp_d;
            ierr_q  <= ierr_d;
            merr_q  <= merr_d;
            req_q   <= req_d;
            valid_q <= valid_d;
        end
    end

    assign mem_req     = req_q;
    assign mem_addr    = addr_q;
    assign icode       = icode_q;
    assign ifun        = ifun_q;
    assign rA          = ra_q;
    assign rB          = rb_q;
    assign valC        = valc_q;
    assign valP        = valp_q;
    assign instr_valid = valid_q;
    assign instr_err   = ierr_q;
    assign imem_error  = merr_q;

endmodule

// File: tb/tb_ifetch_seq.sv
// Directed bench for ifetch_seq: byte-addressed memory responder with programmable ack gaps,
// expected decodes queued per fetch and compared when instr_valid appears.
module tb_ifetch_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] pc_in;
    logic        pc_valid;
    logic        mem_req;
    logic [63:0] mem_addr;
    logic        mem_ack;
    logic [7:0]  mem_rdata;
    logic        mem_err;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP;
    logic        instr_valid;
    logic        instr_ready;
    logic        instr_err;
    logic        imem_error;

    always #5 clk = ~clk;

    ifetch_seq dut (
        .clk(clk), .reset(reset), .pc_in(pc_in), .pc_valid(pc_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .mem_err(mem_err), .icode(icode), .ifun(ifun),
        .rA(rA), .rB(rB), .valC(valC), .valP(valP), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .instr_err(instr_err), .imem_error(imem_error)
    );

    typedef struct {
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        ierr, merr;
        int          nreq;
    } exp_t;

    int          tests = 0;
    int          fails = 0;
    logic [7:0]  mem [logic [63:0]];
    exp_t        sb [$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rd(input logic [63:0] a);
        if (mem.exists(a)) return mem[a];
        else return 8'h00;
    endfunction

    task automatic load(input logic [63:0] base, input logic [7:0] b [10], input int n);
        for (int i = 0; i < n; i++) mem[base + 64'(i)] = b[i];
    endtask

    task automatic push(input logic [3:0] ic, input logic [3:0] fn, input logic [3:0] ra,
                        input logic [3:0] rb, input logic [63:0] vc, input logic [63:0] vp,
                        input logic ie, input logic me, input int nreq);
        exp_t e;
        e.icode = ic; e.ifun = fn; e.ra = ra; e.rb = rb;
        e.valc = vc; e.valp = vp; e.ierr = ie; e.merr = me; e.nreq = nreq;
        sb.push_back(e);
    endtask

    // Runs one fetch. err_at: ack index carrying mem_err; abort_at: ack index at which reset hits.
    task automatic fetch(input logic [63:0] pc, input int maxgap, input int first_gap,
                         input int err_at, input int abort_at, input int exp_lat);
        logic [63:0] exp_addr;
        int nacks = 0;
        int wait_cnt = 0;
        int gap = first_gap;
        int cyc;
        bit done = 1'b0;
        exp_t e;
        pc_in = pc; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0; pc_in = 64'd0;
        cyc = 1;
        exp_addr = pc;
        while (!done && cyc < 200) begin
            mem_ack = 1'b0; mem_err = 1'b0; mem_rdata = 8'h00;
            if (instr_valid) begin
                done = 1'b1;
            end else if (mem_req) begin
                chk("mem_addr", mem_addr, exp_addr);
                if (nacks == abort_at) begin
                    // Reset collides with ack, pc_valid and instr_ready in the same cycle.
                    reset = 1'b1; mem_ack = 1'b1; mem_rdata = rd(exp_addr);
                    pc_valid = 1'b1; pc_in = 64'h999; instr_ready = 1'b1;
                    tick();
                    chk("abort_mem_req", {63'd0, mem_req}, 64'd0);
                    chk("abort_valid", {63'd0, instr_valid}, 64'd0);
                    chk("abort_addr", mem_addr, 64'd0);
                    chk("abort_valc", valC, 64'd0);
                    chk("abort_ra", {60'd0, rA}, 64'hF);
                    reset = 1'b0; mem_ack = 1'b0; pc_valid = 1'b0; instr_ready = 1'b0;
                    tick();
                    chk("abort_noqueue", {63'd0, mem_req}, 64'd0);
                    return;
                end
                if (wait_cnt >= gap) begin
                    mem_ack = 1'b1;
                    mem_rdata = rd(exp_addr);
                    mem_err = (nacks == err_at);
                    nacks++;
                    exp_addr = exp_addr + 64'd1;
                    wait_cnt = 0;
                    gap = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
                end else begin
                    wait_cnt++;
                end
            end
            if (!done) begin
                tick();
                cyc++;
            end
        end
        mem_ack = 1'b0; mem_err = 1'b0;
        if (!done) begin
            chk("instr_valid_timeout", {63'd0, instr_valid}, 64'd1);
            return;
        end
        if (sb.size() == 0) begin
            chk("scoreboard_empty_at_output", 64'(sb.size()), 64'd1);
            return;
        end
        e = sb.pop_front();
        if (exp_lat >= 0) chk("latency", 64'(cyc), 64'(exp_lat));
        chk("icode", {60'd0, icode}, {60'd0, e.icode});
        chk("ifun", {60'd0, ifun}, {60'd0, e.ifun});
        chk("rA", {60'd0, rA}, {60'd0, e.ra});
        chk("rB", {60'd0, rB}, {60'd0, e.rb});
        chk("valC", valC, e.valc);
        chk("valP", valP, e.valp);
        chk("instr_err", {63'd0, instr_err}, {63'd0, e.ierr});
        chk("imem_error", {63'd0, imem_error}, {63'd0, e.merr});
        chk("nreq", 64'(nacks), 64'(e.nreq));
        chk("done_mem_req", {63'd0, mem_req}, 64'd0);
        repeat (2) tick();
        chk("hold_valid", {63'd0, instr_valid}, 64'd1);
        chk("hold_valC", valC, e.valc);
        chk("hold_valP", valP, e.valp);
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("valid_drop", {63'd0, instr_valid}, 64'd0);
    endtask

    task automatic check_halted();
        pc_in = 64'h100; pc_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("halt_mem_req", {63'd0, mem_req}, 64'd0);
            chk("halt_valid", {63'd0, instr_valid}, 64'd0);
        end
        pc_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] b [10];
        reset = 1'b1; pc_in = 64'd0; pc_valid = 1'b0; mem_ack = 1'b0;
        mem_rdata = 8'h00; mem_err = 1'b0; instr_ready = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", {63'd0, mem_req}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_valid", {63'd0, instr_valid}, 64'd0);
        chk("rst_icode", {60'd0, icode}, 64'd0);
        chk("rst_ifun", {60'd0, ifun}, 64'd0);
        chk("rst_rA", {60'd0, rA}, 64'hF);
        chk("rst_rB", {60'd0, rB}, 64'hF);
        chk("rst_valC", valC, 64'd0);
        chk("rst_valP", valP, 64'd0);
        chk("rst_errs", {62'd0, instr_err, imem_error}, 64'd0);
        reset = 1'b0;
        tick();

        // nop, ack one cycle after the request: instr_valid three cycles after pc_valid
        b = '{8'h10, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'h100, b, 1);
        push(4'h1, 4'h0, 4'hF, 4'hF, 64'd0, 64'h101, 1'b0, 1'b0, 1);
        fetch(64'h100, 0, 1, -1, -1, 3);

        // stray acks while idle must not start anything
        mem_ack = 1'b1; mem_rdata = 8'h30;
        tick();
        tick();
        chk("stray_ack_req", {63'd0, mem_req}, 64'd0);
        chk("stray_ack_valid", {63'd0, instr_valid}, 64'd0);
        mem_ack = 1'b0;

        // irmovq, back-to-back acks
        b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        load(64'h0, b, 10);
        push(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'hA, 1'b0, 1'b0, 10);
        fetch(64'h0, 0, 0, -1, -1, -1);

        // jmp with random ack gaps
        b = '{8'h70, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'h20, b, 9);
        push(4'h7, 4'h0, 4'hF, 4'hF, 64'hDEADBEEF, 64'h29, 1'b0, 1'b0, 9);
        fetch(64'h20, 3, 2, -1, -1, -1);

        // reset while byte 4 of an irmovq is requested, then a clean refetch
        b = '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        load(64'h200, b, 10);
        fetch(64'h200, 0, 0, -1, 4, -1);
        push(4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'h20A, 1'b0, 1'b0, 10);
        fetch(64'h200, 1, 0, -1, -1, -1);

        // illegal icode
        b = '{8'hC0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'h40, b, 1);
        push(4'hC, 4'h0, 4'hF, 4'hF, 64'd0, 64'h41, 1'b1, 1'b0, 1);
        fetch(64'h40, 0, 0, -1, -1, -1);
        check_halted();
        do_reset();

        // halt instruction
        b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'h50, b, 1);
        push(4'h0, 4'h0, 4'hF, 4'hF, 64'd0, 64'h51, 1'b0, 1'b0, 1);
        fetch(64'h50, 0, 0, -1, -1, -1);
        check_halted();
        do_reset();

        // memory error on the second byte, address wraps to zero
        b = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load(64'hFFFF_FFFF_FFFF_FFFF, b, 1);
        push(4'h6, 4'h0, 4'hF, 4'hF, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 2);
        fetch(64'hFFFF_FFFF_FFFF_FFFF, 0, 0, 1, -1, -1);
        check_halted();

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
